// File: rtl/tow_game_ctrl.sv
// Tug-of-War round sequencer: intro, dark countdown, live play, winner blink.
// Optional macro TOW_FALSE_START_EN turns presses during the dark countdown into false starts.
module tow_game_ctrl #(
    parameter int SHOW_CYC  = 16,
    parameter int DARK_CYC  = 8,
    parameter int BLINK_CYC = 4,
    parameter int CNT_W     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [1:0] led_ctrl,
    output logic [6:0] score,
    output logic [1:0] winner
);

    localparam logic [1:0] LED_ALL   = 2'b11;
    localparam logic [1:0] LED_SCORE = 2'b10;
    localparam logic [1:0] LED_DARK  = 2'b00;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam logic [6:0] CENTRE = 7'b0001000;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] DARK_LAST  = CNT_W'(DARK_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_DARK = 2'd1,
        ST_PLAY = 2'd2,
        ST_WIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       led_q, led_d;
    logic [6:0]       score_q, score_d;
    logic [1:0]       winner_q, winner_d;
    logic             btn_l_q, btn_r_q;

    logic press_l, press_r;
    logic move_l, move_r;

    // Simultaneous presses from both players cancel each other.
    assign press_l = btn_l & ~btn_l_q;
    assign press_r = btn_r & ~btn_r_q;
    assign move_l  = press_l & ~press_r;
    assign move_r  = press_r & ~press_l;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_ONE;
        led_d    = led_q;
        score_d  = score_q;
        winner_d = winner_q;

        if (start) begin
            state_d  = ST_INIT;
            cnt_d    = '0;
            led_d    = LED_ALL;
            score_d  = CENTRE;
            winner_d = WIN_NONE;
        end else begin
            case (state_q)
                ST_INIT: begin
                    led_d   = LED_ALL;
                    score_d = CENTRE;
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_DARK;
                        cnt_d   = '0;
                        led_d   = LED_DARK;
                    end
                end

                ST_DARK: begin
                    led_d = LED_DARK;
                    if (cnt_q == DARK_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                        led_d   = LED_SCORE;
                    end
`ifdef TOW_FALSE_START_EN
                    // A false start pulls the rope toward the opponent.
                    if (move_l) begin
                        score_d = score_q >> 1;
                        if (score_q[1]) begin
                            state_d  = ST_WIN;
                            cnt_d    = '0;
                            led_d    = LED_SCORE;
                            winner_d = WIN_RIGHT;
                        end
                    end else if (move_r) begin
                        score_d = score_q << 1;
                        if (score_q[5]) begin
                            state_d  = ST_WIN;
                            cnt_d    = '0;
                            led_d    = LED_SCORE;
                            winner_d = WIN_LEFT;
                        end
                    end
`endif
                end

                ST_PLAY: begin
                    led_d = LED_SCORE;
                    if (move_l) begin
                        score_d = score_q << 1;
                        if (score_q[5]) begin
                            state_d  = ST_WIN;
                            cnt_d    = '0;
                            winner_d = WIN_LEFT;
                        end
                    end else if (move_r) begin
                        score_d = score_q >> 1;
                        if (score_q[1]) begin
                            state_d  = ST_WIN;
                            cnt_d    = '0;
                            winner_d = WIN_RIGHT;
                        end
                    end
                end

                ST_WIN: begin
                    if (cnt_q == BLINK_LAST) begin
                        cnt_d = '0;
                        led_d = (led_q == LED_SCORE) ? LED_DARK : LED_SCORE;
                    end
                end

                default: begin
                    state_d  = ST_INIT;
                    cnt_d    = '0;
                    led_d    = LED_ALL;
                    score_d  = CENTRE;
                    winner_d = WIN_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            led_q    <= LED_ALL;
            score_q  <= CENTRE;
            winner_q <= WIN_NONE;
            btn_l_q  <= 1'b0;
            btn_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            score_q  <= score_d;
            winner_q <= winner_d;
            btn_l_q  <= btn_l;
            btn_r_q  <= btn_r;
        end
    end

    assign led_ctrl = led_q;
    assign score    = score_q;
    assign winner   = winner_q;

endmodule

// File: tb/tb_tow_game_ctrl.sv
// Bench for tow_game_ctrl: directed round scenarios plus random button traffic,
// checked each cycle against a round-timeline model (elapsed time, rope index, win time).
module tb_tow_game_ctrl;

    localparam int SHOW  = 16;
    localparam int DARK  = 8;
    localparam int BLINK = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       btn_l;
    logic       btn_r;
    logic [1:0] led_ctrl;
    logic [6:0] score;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    // Model: t = edges since round start, pos = rope index (0 right end .. 6 left end),
    // k = edges since the round was decided.
    int       t;
    int       pos;
    int       k;
    bit       won;
    bit [1:0] win_code;
    bit       prev_l;
    bit       prev_r;

    tow_game_ctrl #(
        .SHOW_CYC (SHOW),
        .DARK_CYC (DARK),
        .BLINK_CYC(BLINK),
        .CNT_W    (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .btn_l   (btn_l),
        .btn_r   (btn_r),
        .led_ctrl(led_ctrl),
        .score   (score),
        .winner  (winner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        t = 0; pos = 3; k = 0; won = 0; win_code = 2'b00; prev_l = 0; prev_r = 0;
    endtask

    task automatic model_edge(input bit l, input bit r, input bit s);
        bit pl, pr, can_move, left_dir;
        pl = l && !prev_l;
        pr = r && !prev_r;
        prev_l = l;
        prev_r = r;
        if (s) begin
            t = 0; pos = 3; k = 0; won = 0; win_code = 2'b00;
        end else if (won) begin
            k++;
        end else begin
            can_move = 0;
            left_dir = 0;
            if (t >= SHOW + DARK) begin
                can_move = (pl != pr);
                left_dir = pl;
            end
`ifdef TOW_FALSE_START_EN
            else if (t >= SHOW) begin
                can_move = (pl != pr);
                left_dir = pr;
            end
`endif
            if (can_move) begin
                pos += left_dir ? 1 : -1;
                if (pos == 6) begin won = 1; win_code = 2'b01; k = 0; end
                else if (pos == 0) begin won = 1; win_code = 2'b10; k = 0; end
            end
            t++;
        end
    endtask

    function automatic logic [1:0] exp_led();
        if (won) return (((k / BLINK) % 2) == 0) ? 2'b10 : 2'b00;
        if (t < SHOW) return 2'b11;
        if (t < SHOW + DARK) return 2'b00;
        return 2'b10;
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [6:0] e_score;
        e_score = 7'd1 << pos;
        check("led_ctrl", {5'd0, led_ctrl}, {5'd0, exp_led()});
        check("score", score, e_score);
        check("winner", {5'd0, winner}, {5'd0, win_code});
    endtask

    task automatic cycle(input bit l, input bit r, input bit s);
        btn_l = l; btn_r = r; start = s;
        @(posedge clk);
        model_edge(l, r, s);
        #1;
        check_all();
        $display("cyc t=%0d l=%0d r=%0d s=%0d led=%b score=%b win=%b", t, l, r, s, led_ctrl, score, winner);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    initial begin
        bit rl, rr;
        rst_n = 1'b0; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Intro, dark and start of play timeline.
        idle(SHOW + DARK + 2);

        // Three left pulses to a left win, then watch the blink.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            idle(2);
        end
        idle(3 * BLINK + 1);

        // Restart, simultaneous presses, then a held right button.
        cycle(0, 0, 1);
        idle(SHOW + DARK);
        cycle(1, 1, 0);
        idle(2);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0);
        idle(1);
        cycle(0, 1, 0); idle(1);
        cycle(0, 1, 0); idle(1);
        idle(2 * BLINK);

        // Restart from a right win; next round intro/dark timing.
        cycle(0, 0, 1);
        idle(SHOW + 2);

        // Button held across the dark-to-play boundary.
        cycle(0, 0, 1);
        idle(SHOW + 4);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        idle(3);

        // Three left presses during the dark countdown.
        cycle(0, 0, 1);
        idle(SHOW + 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
        idle(DARK + 2);

        // start held keeps the intro pinned.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);
        idle(3);

        // Random button traffic with occasional restarts.
        rl = 0; rr = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rl = !rl;
            if ($urandom_range(0, 3) == 0) rr = !rr;
            cycle(rl, rr, $urandom_range(0, 149) == 0);
        end

        // Asynchronous reset in the middle of play with the rope at bit 5.
        cycle(0, 0, 1);
        idle(SHOW + DARK + 1);
        cycle(1, 0, 0); idle(1);
        cycle(1, 0, 0); idle(1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_led", {5'd0, led_ctrl}, 7'b0000011);
        check("rst_score", score, 7'b0001000);
        check("rst_winner", {5'd0, winner}, 7'd0);
        #2;
        rst_n = 1'b1;
        idle(SHOW + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
